// File: rtl/i2c_target_regfile.sv
// I2C target exposing NREGS 8-bit registers behind an auto-incrementing pointer.
// Bus pins are oversampled on clk; sda is open-drain and is only ever pulled low.
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'b0101010,
   parameter int         NREGS    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     scl,
   inout  wire                      sda,
   output logic [8*NREGS-1:0]       regs_out,
   output logic                     wr_strobe,
   output logic [$clog2(NREGS)-1:0] wr_index,
   output logic                     busy
);

   localparam int PW = $clog2(NREGS);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      ADDR      = 4'd1,
      ADDR_ACK  = 4'd2,
      PTR       = 4'd3,
      PTR_ACK   = 4'd4,
      WDATA     = 4'd5,
      WDATA_ACK = 4'd6,
      RDATA     = 4'd7,
      RDATA_ACK = 4'd8
   } state_t;

   logic [1:0]    scl_sync_r;
   logic [1:0]    sda_sync_r;
   logic          scl_d_r;
   logic          sda_d_r;
   logic          scl_s;
   logic          sda_s;
   logic          scl_rise_s;
   logic          scl_fall_s;
   logic          start_s;
   logic          stop_s;

   state_t        state_r;
   state_t        state_nx;
   logic [3:0]    bit_cnt_r;
   logic [3:0]    bit_cnt_nx;
   logic [7:0]    shift_r;
   logic [7:0]    shift_nx;
   logic [7:0]    shift_in_s;
   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_nx;
   logic          sda_oe_r;
   logic          sda_oe_nx;
   logic          busy_r;
   logic          busy_nx;
   logic          rw_r;
   logic          rw_nx;
   logic          wr_en_s;
   logic [7:0]    wr_data_s;
   logic [7:0]    rd_byte_s;
   logic [7:0]    regs_r [NREGS];
   logic          wr_strobe_r;
   logic [PW-1:0] wr_index_r;

   // Two-flop synchronizers plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_r <= 2'b11;
         sda_sync_r <= 2'b11;
         scl_d_r    <= 1'b1;
         sda_d_r    <= 1'b1;
      end else begin
         scl_sync_r <= {scl_sync_r[0], scl};
         sda_sync_r <= {sda_sync_r[0], sda};
         scl_d_r    <= scl_s;
         sda_d_r    <= sda_s;
      end
   end

   assign scl_s      = scl_sync_r[1];
   assign sda_s      = sda_sync_r[1];
   assign scl_rise_s = scl_s & ~scl_d_r;
   assign scl_fall_s = ~scl_s & scl_d_r;
   assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
   assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
   assign shift_in_s = {shift_r[6:0], sda_s};
   assign rd_byte_s  = regs_r[ptr_r];

   // Protocol state machine: sample on scl rise, change sda drive on scl fall.
   always_comb begin
      state_nx   = state_r;
      bit_cnt_nx = bit_cnt_r;
      shift_nx   = shift_r;
      ptr_nx     = ptr_r;
      sda_oe_nx  = sda_oe_r;
      busy_nx    = busy_r;
      rw_nx      = rw_r;
      wr_en_s    = 1'b0;
      wr_data_s  = shift_in_s;

      if (stop_s) begin
         state_nx   = IDLE;
         bit_cnt_nx = 4'd0;
         sda_oe_nx  = 1'b0;
         busy_nx    = 1'b0;
      end else if (start_s) begin
         state_nx   = ADDR;
         bit_cnt_nx = 4'd0;
         sda_oe_nx  = 1'b0;
         busy_nx    = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               sda_oe_nx = 1'b0;
               busy_nx   = 1'b0;
            end
            ADDR: begin
               if (scl_rise_s) begin
                  shift_nx   = shift_in_s;
                  bit_cnt_nx = bit_cnt_r + 4'd1;
               end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                  if (shift_r[7:1] == DEV_ADDR) begin
                     state_nx  = ADDR_ACK;
                     sda_oe_nx = 1'b1;
                     busy_nx   = 1'b1;
                     rw_nx     = shift_r[0];
                  end else begin
                     state_nx  = IDLE;
                  end
               end else begin
                  state_nx = ADDR;
               end
            end
            ADDR_ACK: begin
               if (scl_fall_s) begin
                  bit_cnt_nx = 4'd0;
                  if (rw_r) begin
                     state_nx  = RDATA;
                     shift_nx  = rd_byte_s;
                     sda_oe_nx = ~rd_byte_s[7];
                  end else begin
                     state_nx  = PTR;
                     sda_oe_nx = 1'b0;
                  end
               end else begin
                  state_nx = ADDR_ACK;
               end
            end
            PTR: begin
               if (scl_rise_s) begin
                  shift_nx   = shift_in_s;
                  bit_cnt_nx = bit_cnt_r + 4'd1;
               end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                  ptr_nx    = shift_r[PW-1:0];
                  state_nx  = PTR_ACK;
                  sda_oe_nx = 1'b1;
               end else begin
                  state_nx = PTR;
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall_s) begin
                  state_nx   = WDATA;
                  bit_cnt_nx = 4'd0;
                  sda_oe_nx  = 1'b0;
               end else begin
                  state_nx = state_r;
               end
            end
            WDATA: begin
               // The register commits on the 8th bit so a mid-byte abort leaves it intact.
               if (scl_rise_s) begin
                  shift_nx   = shift_in_s;
                  bit_cnt_nx = bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd7) begin
                     wr_en_s = 1'b1;
                     ptr_nx  = ptr_r + PW'(1'b1);
                  end else begin
                     wr_en_s = 1'b0;
                  end
               end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                  state_nx  = WDATA_ACK;
                  sda_oe_nx = 1'b1;
               end else begin
                  state_nx = WDATA;
               end
            end
            RDATA: begin
               if (scl_rise_s) begin
                  bit_cnt_nx = bit_cnt_r + 4'd1;
               end else if (scl_fall_s) begin
                  if (bit_cnt_r == 4'd8) begin
                     state_nx   = RDATA_ACK;
                     bit_cnt_nx = 4'd0;
                     sda_oe_nx  = 1'b0;
                  end else begin
                     shift_nx  = {shift_r[6:0], 1'b0};
                     sda_oe_nx = ~shift_r[6];
                  end
               end else begin
                  state_nx = RDATA;
               end
            end
            RDATA_ACK: begin
               // bit_cnt doubles as the "master acknowledged" flag until the next fall.
               if (scl_rise_s) begin
                  if (!sda_s) begin
                     ptr_nx     = ptr_r + PW'(1'b1);
                     bit_cnt_nx = 4'd1;
                  end else begin
                     state_nx  = IDLE;
                     sda_oe_nx = 1'b0;
                     busy_nx   = 1'b0;
                  end
               end else if (scl_fall_s && (bit_cnt_r == 4'd1)) begin
                  state_nx   = RDATA;
                  bit_cnt_nx = 4'd0;
                  shift_nx   = rd_byte_s;
                  sda_oe_nx  = ~rd_byte_s[7];
               end else begin
                  state_nx = RDATA_ACK;
               end
            end
            default: begin
               state_nx  = IDLE;
               sda_oe_nx = 1'b0;
               busy_nx   = 1'b0;
            end
         endcase
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         bit_cnt_r <= 4'd0;
         shift_r   <= 8'h00;
         ptr_r     <= '0;
         sda_oe_r  <= 1'b0;
         busy_r    <= 1'b0;
         rw_r      <= 1'b0;
      end else begin
         state_r   <= state_nx;
         bit_cnt_r <= bit_cnt_nx;
         shift_r   <= shift_nx;
         ptr_r     <= ptr_nx;
         sda_oe_r  <= sda_oe_nx;
         busy_r    <= busy_nx;
         rw_r      <= rw_nx;
      end
   end

   // Register file and write notification.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_r[k] <= 8'h00;
         end
         wr_strobe_r <= 1'b0;
         wr_index_r  <= '0;
      end else begin
         wr_strobe_r <= wr_en_s;
         if (wr_en_s) begin
            regs_r[ptr_r] <= wr_data_s;
            wr_index_r    <= ptr_r;
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
      assign regs_out[8*g +: 8] = regs_r[g];
   end

   assign sda       = sda_oe_r ? 1'b0 : 1'bz;
   assign wr_strobe = wr_strobe_r;
   assign wr_index  = wr_index_r;
   assign busy      = busy_r;

endmodule
